// File: rtl/mips_mc_control_if.sv
// Purpose: control-to-datapath bundle for the multicycle MIPS main control FSM.
// Latency: none; this is a wiring bundle.
// Backpressure: mem_ready from memory stalls the FSM in its memory states.
// Ports: opcode/zero/mem_ready flow datapath->control; enables, mux selects,
//        alu_op, illegal, state and retired flow control->datapath.
interface mips_mc_control_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_en;
  logic             ir_write;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       pc_source;
  logic [2:0]       alu_op;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  // master = control FSM, slave = datapath/memory side
  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_op, illegal,
           state, retired
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_op, illegal,
           state, retired
  );
endinterface

// File: rtl/mips_mc_control.sv
// Purpose: multicycle MIPS main control FSM with retired-instruction counter.
// Latency: controls are combinational from state; CPI lw=5, sw/R/I=4, br/j=3.
// Backpressure: FETCH, MEMRD and MEMWR hold their requests until mem_ready.
// Ports: clk, rst_n (async active-low), bus (mips_mc_control_if.master).
module mips_mc_control #(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  mips_mc_control_if.master   bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXE   = 4'd6,
    S_ALUWB   = 4'd7,
    S_IEXE    = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_ILLEGAL = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t           state_q;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q;
  logic             retire;

  // High on the cycle whose closing edge leaves a retiring state.
  always_comb begin
    case (state_q)
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEMWR:                            retire = bus.mem_ready;
      default:                            retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (retire) retired_q <= retired_q + 1'b1;
      case (state_q)
        S_FETCH:  if (bus.mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_LW, OP_SW:                     state_q <= S_MEMADR;
            OP_R:                             state_q <= S_RTEXE;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_q <= S_IEXE;
            OP_BEQ, OP_BNE:                   state_q <= S_BRANCH;
            OP_J:                             state_q <= S_JUMP;
            default: begin
              state_q   <= S_ILLEGAL;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_MEMADR: state_q <= (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (bus.mem_ready) state_q <= S_MEMWB;
        S_MEMWR:  if (bus.mem_ready) state_q <= S_FETCH;
        S_RTEXE, S_IEXE:                     state_q <= S_ALUWB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP:  state_q <= S_FETCH;
        // Only a reset leaves ILLEGAL.
        S_ILLEGAL: state_q <= S_ILLEGAL;
        default:   state_q <= S_FETCH;
      endcase
    end
  end

  logic       pc_en, ir_write, iord, mem_read, mem_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;

  always_comb begin
    pc_en      = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    alu_op     = 3'b000;
    // The state register resets to FETCH, which would otherwise raise
    // mem_read while reset is still held.
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = bus.mem_ready;
          pc_en     = bus.mem_ready;
        end
        S_DECODE: alu_src_b = 2'b11;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_RTEXE: begin
          alu_src_a = 1'b1;
          alu_op    = 3'b111;
        end
        S_IEXE: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          case (bus.opcode)
            OP_ANDI: alu_op = 3'b100;
            OP_ORI:  alu_op = 3'b101;
            OP_SLTI: alu_op = 3'b001;
            default: alu_op = 3'b000;
          endcase
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = (bus.opcode == OP_R);
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 3'b010;
          pc_source = 2'b01;
          // ALUOut holds the target computed in DECODE; the subtract sets zero.
          pc_en     = (bus.opcode == OP_BNE) ? !bus.zero : bus.zero;
        end
        S_JUMP: begin
          pc_source = 2'b10;
          pc_en     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_en      = pc_en;
  assign bus.ir_write   = ir_write;
  assign bus.iord       = iord;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.reg_write  = reg_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.pc_source  = pc_source;
  assign bus.alu_op     = alu_op;
  assign bus.illegal    = illegal_q;
  assign bus.state      = state_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_mips_mc_control.sv
module tb_mips_mc_control;

  localparam int W = 4;

  localparam logic [5:0] R_OP = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101, SLTI = 6'b001010;
  localparam logic [5:0] JMP = 6'b000010, BAD = 6'b111111;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   wr_cnt;
  int   tk_cnt;

  mips_mc_control_if #(.CNT_W(W)) bus();

  mips_mc_control #(.CNT_W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-level model: the step being executed plus the steps the
  // decoded instruction still has to walk through.
  int m_ph;
  int m_ret;
  int m_ill;
  int path[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph  = 0;
      m_ret = 0;
      m_ill = 0;
      path.delete();
    end else if (m_ph == 0) begin
      if (bus.mem_ready) m_ph = 1;
    end else if (m_ph == 1) begin
      case (bus.opcode)
        LW:                     path = '{2, 3, 4};
        SW:                     path = '{2, 5};
        R_OP:                   path = '{6, 7};
        ADDI, ANDI, ORI, SLTI:  path = '{8, 7};
        BEQ, BNE:               path = '{9};
        JMP:                    path = '{10};
        default:                path = '{11};
      endcase
      m_ph = path.pop_front();
      if (m_ph == 11) m_ill = 1;
    end else if (m_ph == 11) begin
      m_ph = 11;
    end else if ((m_ph == 3 || m_ph == 5) && !bus.mem_ready) begin
      m_ph = m_ph;
    end else if (path.size() == 0) begin
      m_ret = (m_ret + 1) % (1 << W);
      m_ph  = 0;
    end else begin
      m_ph = path.pop_front();
    end
  end

  // Control word the step must present:
  // {pc_en, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
  //  mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_op}
  function automatic logic [15:0] exp_ctl(input int ph, input logic [5:0] op,
                                          input logic z, input logic mr,
                                          input logic rn);
    logic pe, irw, io, mrd, mwr, rw, rd, m2r, sa;
    logic [1:0] sb, ps;
    logic [2:0] ao;
    {pe, irw, io, mrd, mwr, rw, rd, m2r, sa} = '0;
    sb = 2'b00; ps = 2'b00; ao = 3'b000;
    if (rn) begin
      case (ph)
        0:  begin mrd = 1; sb = 2'b01; pe = mr; irw = mr; end
        1:  sb = 2'b11;
        2:  begin sa = 1; sb = 2'b10; end
        3:  begin mrd = 1; io = 1; end
        4:  begin rw = 1; m2r = 1; end
        5:  begin mwr = 1; io = 1; end
        6:  begin sa = 1; ao = 3'b111; end
        7:  begin rw = 1; rd = (op == R_OP); end
        8:  begin
          sa = 1; sb = 2'b10;
          ao = (op == ANDI) ? 3'b100 : (op == ORI) ? 3'b101 :
               (op == SLTI) ? 3'b001 : 3'b000;
        end
        9:  begin sa = 1; ao = 3'b010; ps = 2'b01; pe = (op == BEQ) ? z : !z; end
        10: begin ps = 2'b10; pe = 1; end
        default: ;
      endcase
    end
    return {pe, irw, io, mrd, mwr, rw, rd, m2r, sa, sb, ps, ao};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input logic mr);
    bus.mem_ready = mr;
    @(posedge clk);
    #2;
  endtask

  // fw = FETCH wait cycles, mw = wait cycles in the data memory step.
  task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
    int n;
    int mi;
    bus.opcode = op;
    bus.zero   = z;
    repeat (fw) tick(1'b0);
    tick(1'b1);
    mi = -1;
    case (op)
      LW:           begin n = 4; mi = 2; end
      SW:           begin n = 3; mi = 2; end
      BEQ, BNE, JMP: n = 2;
      default:      n = 3;
    endcase
    for (int i = 0; i < n; i++) begin
      if (i == mi) repeat (mw) tick(1'b0);
      tick(1'b1);
    end
  endtask

  initial begin
    int w0;
    int t0;
    n_chk = 0; n_fail = 0; wr_cnt = 0; tk_cnt = 0;
    rst_n = 1'b0;
    bus.opcode = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        chk("ctl", {bus.pc_en, bus.ir_write, bus.iord, bus.mem_read, bus.mem_write,
                    bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                    bus.alu_src_b, bus.pc_source, bus.alu_op},
            exp_ctl(m_ph, bus.opcode, bus.zero, bus.mem_ready, rst_n));
        chk("state", bus.state, m_ph);
        chk("retired", bus.retired, m_ret);
        chk("illegal", bus.illegal, m_ill);
        if (bus.mem_write) wr_cnt++;
        if (bus.state == 4'd9 && bus.pc_en) tk_cnt++;
      end
    join_none

    repeat (2) @(posedge clk);
    #2;
    chk("rst_state", bus.state, 0);
    chk("rst_mem_read", bus.mem_read, 0);
    rst_n = 1'b1;

    run_instr(LW, 1'b0, 0, 0);
    chk("lw_retired", bus.retired, 1);
    chk("lw_state", bus.state, 0);

    w0 = wr_cnt;
    run_instr(SW, 1'b0, 0, 3);
    chk("sw_wr_cycles", wr_cnt - w0, 4);
    chk("sw_retired", bus.retired, 2);

    run_instr(R_OP, 1'b0, 0, 0);
    run_instr(ADDI, 1'b0, 0, 0);
    run_instr(ORI, 1'b0, 0, 0);
    run_instr(ANDI, 1'b0, 0, 0);
    run_instr(SLTI, 1'b0, 0, 0);

    t0 = tk_cnt;
    run_instr(BEQ, 1'b1, 0, 0);
    run_instr(BEQ, 1'b0, 0, 0);
    run_instr(BNE, 1'b1, 0, 0);
    run_instr(BNE, 1'b0, 0, 0);
    chk("br_taken", tk_cnt - t0, 2);

    run_instr(LW, 1'b0, 2, 1);
    chk("mix_retired", bus.retired, 12);

    bus.opcode = BAD;
    tick(1'b1);
    repeat (21) tick(1'b1);
    chk("ill_state", bus.state, 11);
    chk("ill_flag", bus.illegal, 1);
    rst_n = 1'b0;
    #1;
    chk("ill_rst_state", bus.state, 0);
    chk("ill_rst_flag", bus.illegal, 0);
    chk("ill_rst_mem_read", bus.mem_read, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    repeat (15) run_instr(JMP, 1'b0, 0, 0);
    chk("j15_retired", bus.retired, 15);
    run_instr(JMP, 1'b0, 0, 0);
    chk("wrap_retired", bus.retired, 0);

    bus.opcode = LW;
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    chk("memrd_state", bus.state, 3);
    tick(1'b0);
    rst_n = 1'b0;
    #1;
    chk("memrd_rst_state", bus.state, 0);
    chk("memrd_rst_mem_read", bus.mem_read, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_instr(LW, 1'b0, 0, 0);
    chk("post_rst_retired", bus.retired, 1);

    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multicycle MIPS main control FSM.
- Decodes the IR opcode and sequences the datapath through fetch, decode, execute, memory and writeback.
- Produces the 3-bit alu_op that the ALU control decoder consumes, alongside the function field.
- Handles variable-latency memory through a mem_ready handshake and counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]; stable from DECODE until the instruction's final state
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current read/write this cycle
pc_en  out  1  PC write enable
ir_write  out  1  IR load enable
iord  out  1  0=PC address, 1=ALUOut address
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=MDR
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
alu_op  out  3  to ALU control
illegal  out  1  sticky unsupported-opcode flag
state  out  4  current state (debug)
retired  out  CNT_W  retired instruction count

Behaviour:
- Opcode classes: R=000000, lw=100011, sw=101011, beq=000100, bne=000101, addi=001000, andi=001100, ori=001101, slti=001010, j=000010.
- alu_op encoding: 000=add, 010=subtract, 100=and, 101=or, 001=slt, 111=R-type (function field decides).
- Outputs are decoded combinationally from the current state, plus mem_ready, zero and opcode where noted. Any output not listed for a state is 0.
- Reset: state=FETCH(0), retired=0, illegal=0. While rst_n=0, all enables and requests are forced to 0.
- FETCH(0):
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
  - ir_write=pc_en=mem_ready.
  - Stay in FETCH while !mem_ready; else go to DECODE.
- DECODE(1):
  - alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut).
  - Next state: lw/sw→MEMADR, R→RTEXE, addi/andi/ori/slti→IEXE, beq/bne→BRANCH, j→JUMP, other→ILLEGAL.
- MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=000. lw→MEMRD, sw→MEMWR.
- MEMRD(3): mem_read=1, iord=1. Stay while !mem_ready; else go to MEMWB.
- MEMWB(4): reg_write=1, mem_to_reg=1, reg_dst=0. Retires; go to FETCH.
- MEMWR(5): mem_write=1, iord=1. Stay while !mem_ready; on mem_ready retire and go to FETCH.
- RTEXE(6): alu_src_a=1, alu_src_b=00, alu_op=111. Go to ALUWB.
- IEXE(8):
  - alu_src_a=1, alu_src_b=10.
  - alu_op: addi=000, andi=100, ori=101, slti=001.
  - Go to ALUWB.
- ALUWB(7): reg_write=1, mem_to_reg=0, reg_dst=(opcode==R). Retires; go to FETCH.
- BRANCH(9):
  - alu_src_a=1, alu_src_b=00, alu_op=010, pc_source=01.
  - pc_en = zero for beq, !zero for bne.
  - Retires; go to FETCH.
- JUMP(10): pc_source=10, pc_en=1. Retires; go to FETCH.
- ILLEGAL(11):
  - illegal=1, set on entry.
  - All enables 0; hold in ILLEGAL until reset.
- Unused state codes go to FETCH next cycle with all enables 0.
- mem_read and mem_write are never asserted together. Requests hold steady until mem_ready is sampled high.
- retired increments by 1 on the clock edge leaving a retiring state and wraps modulo 2^CNT_W without a flag.
- CPI with zero-wait memory: lw=5, sw=4, R/I-type=4, branch=3, j=3. Each memory wait cycle adds 1.
- rst_n asserted mid-instruction: state and counters clear asynchronously, and no partial write is issued after deassertion.

Test Plan:
- Reset release, mem_ready=1, opcode=100011 (lw) → states 0,1,2,3,4,0; reg_write and mem_to_reg high only in state 4; retired=1.
- sw with mem_ready low for 3 cycles in MEMWR → mem_write=1, iord=1 for 4 cycles, no state advance; retired increments once after ready.
- R-type then addi → alu_op=111 in RTEXE with reg_dst=1 in ALUWB; alu_op=000 in IEXE with reg_dst=0; ori gives alu_op=101.
- beq with zero=1 → pc_en=1, pc_source=01 in state 9. beq with zero=0 → pc_en=0. bne inverts both cases.
- opcode=111111 → ILLEGAL, illegal=1 stays held over 20 cycles with all enables 0; rst_n pulse → state=0, illegal=0.
- Preload retired to all-ones via 2^CNT_W retirements (CNT_W=4 build, 16 j instructions) → retired wraps to 0; reset asserted in MEMRD → state=0 immediately, mem_read=0 during reset.
